// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes, FSM states,
// and the store lane/alignment rules used at request acceptance.
package dmem_responder_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_MAX_LAT    = 4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dmem_state_e;

  // The reserved size encoding is held to word alignment, the strictest rule.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = offset[0];
      default:  is_misaligned = (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input mem_size_e size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: store_mask = 4'b0001 << offset;
      MEM_HALF: store_mask = offset[1] ? 4'b1100 : 4'b0011;
      default:  store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] data);
    case (size)
      MEM_BYTE: store_lanes = {4{data[7:0]}};
      MEM_HALF: store_lanes = {2{data[15:0]}};
      default:  store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory-access stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        WE;
  logic        RE;
  mem_size_e   mem_size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        rsp_valid;
  logic [31:0] read_data;
  logic [31:0] LMD;
  logic        access_err;

  modport master (
    output req_valid, WE, RE, mem_size, load_unsigned, address, write_data,
    input  req_ready, rsp_valid, read_data, LMD, access_err
  );

  modport slave (
    input  req_valid, WE, RE, mem_size, load_unsigned, address, write_data,
    output req_ready, rsp_valid, read_data, LMD, access_err
  );

endinterface

// File: rtl/dmem_responder_load_align_ext.sv
// Picks the addressed byte/half out of a raw memory word and sign- or zero-extends
// it to a full register value.
module load_align_ext
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{offset, 3'b000} +: 8];
    half_v = offset[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_BYTE: value = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      MEM_HALF: value = {{16{~is_unsigned & half_v[15]}}, half_v};
      default:  value = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, byte-lane store masking, and
// registered load responses after a configurable read latency.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(DMEM_MAX_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  dmem_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_off;
  mem_size_e        lat_size;
  logic             lat_uns;

  logic             accept;
  logic             req_err;
  logic             req_store;
  logic             req_load;
  logic [IDX_W-1:0] req_idx;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_lanes;

  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_off;
  mem_size_e        rd_size;
  logic             rd_uns;
  logic [31:0]      rd_word;
  logic [31:0]      rd_ext;

  assign accept    = bus.req_valid && bus.req_ready;
  assign req_err   = (bus.WE && bus.RE) || is_misaligned(bus.mem_size, bus.address[1:0]);
  assign req_store = bus.WE && !req_err;
  assign req_load  = bus.RE && !req_err;
  assign req_idx   = bus.address[IDX_W+1:2];
  assign wr_mask   = store_mask(bus.mem_size, bus.address[1:0]);
  assign wr_lanes  = store_lanes(bus.mem_size, bus.write_data);

  // A latency-1 load reads straight from the request; longer ones use the latched copy.
  assign rd_idx  = (state == DM_IDLE) ? req_idx              : lat_idx;
  assign rd_off  = (state == DM_IDLE) ? bus.address[1:0]     : lat_off;
  assign rd_size = (state == DM_IDLE) ? bus.mem_size         : lat_size;
  assign rd_uns  = (state == DM_IDLE) ? bus.load_unsigned    : lat_uns;
  assign rd_word = mem[rd_idx];

  load_align_ext u_align (
    .word        (rd_word),
    .offset      (rd_off),
    .size        (rd_size),
    .is_unsigned (rd_uns),
    .value       (rd_ext)
  );

  // The array has no reset so a store survives a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (accept && req_store) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[req_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= DM_IDLE;
      cnt            <= '0;
      lat_idx        <= '0;
      lat_off        <= 2'b00;
      lat_size       <= MEM_BYTE;
      lat_uns        <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.read_data  <= '0;
      bus.LMD        <= '0;
      bus.access_err <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        DM_IDLE: begin
          if (accept && (req_err || req_store)) begin
            state          <= DM_RESP;
            bus.req_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.access_err <= req_err;
            bus.read_data  <= '0;
          end else if (accept && req_load) begin
            lat_idx       <= req_idx;
            lat_off       <= bus.address[1:0];
            lat_size      <= bus.mem_size;
            lat_uns       <= bus.load_unsigned;
            bus.req_ready <= 1'b0;
            if (READ_LATENCY == 1) begin
              state          <= DM_RESP;
              bus.rsp_valid  <= 1'b1;
              bus.access_err <= 1'b0;
              bus.read_data  <= rd_word;
              bus.LMD        <= rd_ext;
            end else begin
              state <= DM_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        DM_WAIT: begin
          if (cnt == '0) begin
            state          <= DM_RESP;
            bus.rsp_valid  <= 1'b1;
            bus.access_err <= 1'b0;
            bus.read_data  <= rd_word;
            bus.LMD        <= rd_ext;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DM_RESP: begin
          state          <= DM_IDLE;
          bus.req_ready  <= 1'b1;
          bus.access_err <= 1'b0;
        end
        default: begin
          state         <= DM_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Drives one request stream into a latency-1 and a latency-3 responder side by side
// and scores each response against queued expectations.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int LB = 3;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] lmd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   acc_r;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic due_a, due_b;

  dmem_responder_if ia ();
  dmem_responder_if ib ();

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ia.slave)
  );

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(LB)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ib.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A response is due exactly when the head entry's latency has elapsed.
  always @(negedge clk) begin
    if (rst_n) begin
      due_a = 1'b0;
      if (qa.size() > 0) due_a = ((cyc - qa[0].acc) == qa[0].lat);
      chk("a_rsp_valid", 32'(ia.rsp_valid), 32'(due_a));
      if (due_a) begin
        ea = qa.pop_front();
        chk("a_read_data", ia.read_data, ea.rd);
        chk("a_LMD", ia.LMD, ea.lmd);
        chk("a_access_err", 32'(ia.access_err), 32'(ea.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      due_b = 1'b0;
      if (qb.size() > 0) due_b = ((cyc - qb[0].acc) == qb[0].lat);
      chk("b_rsp_valid", 32'(ib.rsp_valid), 32'(due_b));
      if (due_b) begin
        eb = qb.pop_front();
        chk("b_read_data", ib.read_data, eb.rd);
        chk("b_LMD", ib.LMD, eb.lmd);
        chk("b_access_err", 32'(ib.access_err), 32'(eb.err));
      end
    end
  end

  task automatic drive(input logic v, input logic we, input logic re, input mem_size_e sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    ia.req_valid = v;  ib.req_valid = v;
    ia.WE = we;        ib.WE = we;
    ia.RE = re;        ib.RE = re;
    ia.mem_size = sz;  ib.mem_size = sz;
    ia.load_unsigned = uns; ib.load_unsigned = uns;
    ia.address = addr; ib.address = addr;
    ia.write_data = wd; ib.write_data = wd;
  endtask

  task automatic checkOutput(input string p);
    chk({p, "_a_req_ready"},  32'(ia.req_ready), 32'd1);
    chk({p, "_a_rsp_valid"},  32'(ia.rsp_valid), 32'd0);
    chk({p, "_a_read_data"},  ia.read_data, 32'd0);
    chk({p, "_a_LMD"},        ia.LMD, 32'd0);
    chk({p, "_a_access_err"}, 32'(ia.access_err), 32'd0);
    chk({p, "_b_req_ready"},  32'(ib.req_ready), 32'd1);
    chk({p, "_b_rsp_valid"},  32'(ib.rsp_valid), 32'd0);
    chk({p, "_b_read_data"},  ib.read_data, 32'd0);
    chk({p, "_b_LMD"},        ib.LMD, 32'd0);
    chk({p, "_b_access_err"}, 32'(ib.access_err), 32'd0);
  endtask

  // One request; lat_x of 0 means the request is consumed with no response.
  task automatic applyStimulus(input logic we, input logic re, input mem_size_e sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic [31:0] exp_lmd,
                               input logic exp_err, input int lat_a, input int lat_b);
    exp_t e;
    int   mx;
    @(negedge clk);
    chk("a_ready_at_issue", 32'(ia.req_ready), 32'd1);
    chk("b_ready_at_issue", 32'(ib.req_ready), 32'd1);
    drive(1'b1, we, re, sz, uns, addr, wd);
    e = '{exp_rd, exp_lmd, exp_err, lat_a, cyc};
    if (lat_a > 0) qa.push_back(e);
    e.lat = lat_b;
    if (lat_b > 0) qb.push_back(e);
    mx = (lat_a > lat_b) ? lat_a : lat_b;
    for (int k = 1; k <= mx + 1; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b1, 1'b0, MEM_WORD, 1'b1, 32'h4, 32'hFFFF_FFFF);
      chk("a_req_ready", 32'(ia.req_ready), 32'(k > lat_a));
      chk("b_req_ready", 32'(ib.req_ready), 32'(k > lat_b));
    end
    chk("a_rsp_delivered", 32'(qa.size()), 32'd0);
    chk("b_rsp_delivered", 32'(qb.size()), 32'd0);
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_reset");

    $display("[TB] word store and load");
    applyStimulus(1, 0, MEM_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0,        0, 1, 1);
    applyStimulus(0, 1, MEM_WORD, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 1, LB);

    $display("[TB] byte store and byte loads");
    applyStimulus(1, 0, MEM_BYTE, 0, 32'h11, 32'h1234567F, 32'h0,        32'hDEADBEEF, 0, 1, 1);
    applyStimulus(0, 1, MEM_BYTE, 0, 32'h11, 32'h0,        32'hDEAD7FEF, 32'h0000007F, 0, 1, LB);
    applyStimulus(0, 1, MEM_BYTE, 0, 32'h13, 32'h0,        32'hDEAD7FEF, 32'hFFFFFFDE, 0, 1, LB);
    applyStimulus(0, 1, MEM_BYTE, 1, 32'h13, 32'h0,        32'hDEAD7FEF, 32'h000000DE, 0, 1, LB);

    $display("[TB] half store and half loads");
    applyStimulus(1, 0, MEM_HALF, 0, 32'h12, 32'hAAAA8001, 32'h0,        32'h000000DE, 0, 1, 1);
    applyStimulus(0, 1, MEM_HALF, 0, 32'h12, 32'h0,        32'h80017FEF, 32'hFFFF8001, 0, 1, LB);
    applyStimulus(0, 1, MEM_HALF, 1, 32'h12, 32'h0,        32'h80017FEF, 32'h00008001, 0, 1, LB);
    applyStimulus(0, 1, MEM_HALF, 0, 32'h10, 32'h0,        32'h80017FEF, 32'h00007FEF, 0, 1, LB);
    applyStimulus(0, 1, MEM_BYTE, 0, 32'h10, 32'h0,        32'h80017FEF, 32'hFFFFFFEF, 0, 1, LB);

    $display("[TB] access errors");
    applyStimulus(0, 1, MEM_WORD, 0, 32'h06, 32'h0,        32'h0, 32'hFFFFFFEF, 1, 1, 1);
    applyStimulus(0, 1, MEM_HALF, 0, 32'h01, 32'h0,        32'h0, 32'hFFFFFFEF, 1, 1, 1);
    applyStimulus(1, 0, MEM_WORD, 0, 32'h12, 32'h0,        32'h0, 32'hFFFFFFEF, 1, 1, 1);
    applyStimulus(1, 0, MEM_HALF, 0, 32'h13, 32'h0,        32'h0, 32'hFFFFFFEF, 1, 1, 1);
    applyStimulus(1, 1, MEM_WORD, 0, 32'h10, 32'h0,        32'h0, 32'hFFFFFFEF, 1, 1, 1);

    $display("[TB] silent request, untouched memory, aliasing, top word");
    applyStimulus(0, 0, MEM_WORD, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 1, MEM_WORD, 0, 32'h10,   32'h0,        32'h80017FEF, 32'h80017FEF, 0, 1, LB);
    applyStimulus(0, 1, MEM_WORD, 0, 32'h1010, 32'h0,        32'h80017FEF, 32'h80017FEF, 0, 1, LB);
    applyStimulus(1, 0, MEM_WORD, 0, 32'hFFC,  32'h12345678, 32'h0,        32'h80017FEF, 0, 1, 1);
    applyStimulus(0, 1, MEM_WORD, 0, 32'hFFC,  32'h0,        32'h12345678, 32'h12345678, 0, 1, LB);
    applyStimulus(0, 1, MEM_BYTE, 1, 32'hFFF,  32'h0,        32'h12345678, 32'h00000012, 0, 1, LB);

    $display("[TB] reset while the slow responder waits");
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h10, 32'h0);
    acc_r = cyc;
    qa.push_back('{32'h80017FEF, 32'h80017FEF, 1'b0, 1, acc_r});
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0);
    chk("b_ready_in_wait1", 32'(ib.req_ready), 32'd0);
    @(negedge clk);
    chk("b_ready_in_wait2", 32'(ib.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset");
    @(negedge clk);
    checkOutput("mid_reset_held");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("a_rsp_before_reset", 32'(qa.size()), 32'd0);
    applyStimulus(0, 1, MEM_WORD, 0, 32'h10, 32'h0, 32'h80017FEF, 32'h80017FEF, 0, 1, LB);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
